// File: rtl/core_pkg.sv
// Shared definitions for the LM/SM micro-sequencer: opcodes, instruction
// field positions and the sequencer state encoding.
package core_pkg;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int LIST_MSB = 7;
  localparam int LIST_LSB = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_lm_sm(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Lowest-set-bit encoder: selects the next register of an LM/SM list.
// An empty list yields idx=0 with any=0.
module prio_enc8 (
  input  logic [7:0] in,
  output logic [2:0] idx,
  output logic       any
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the loop leaves it unassigned (no latch).
    idx = 3'd0;
    any = |in;
    // Scan downward so the lowest set bit is the last, and winning, assignment.
    for (int i = 7; i >= 0; i--) begin
      if (in[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM micro-sequencer: expands one load/store-multiple instruction into one
// single-register transfer per cycle, lowest register first, address +1 each.
module lm_sm_sequencer
  import core_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       ir_in,
  input  logic              ir_valid,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  input  logic              flush,
  output logic              stall_fetch,
  output logic              uop_valid,
  output logic              uop_is_load,
  output logic [2:0]        uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic [NREG-1:0]   rem_mask,
  output logic              done
);

  state_t            state;
  logic [NREG-1:0]   mask;
  logic [ADDR_W-1:0] addr;
  logic              is_load;

  logic [3:0]        opcode;
  logic [NREG-1:0]   list;
  logic [NREG-1:0]   mask_next;
  logic              accept;
  logic              run;
  logic [2:0]        low_idx;
  logic              low_any;

  // RA selector and IR[8] are consumed elsewhere; RA arrives as base_addr.
  logic              unused_ir;
  assign unused_ir = ^ir_in[OP_LSB-1:LIST_MSB+1];

  assign opcode    = ir_in[OP_MSB:OP_LSB];
  assign list      = ir_in[LIST_LSB +: NREG];
  assign run       = (state == RUN);
  assign accept    = (state == IDLE) && ir_valid && is_lm_sm(opcode) && !hold && !flush;
  assign mask_next = mask & (mask - NREG'(1));

  prio_enc8 u_prio_enc8 (
    .in  (mask),
    .idx (low_idx),
    .any (low_any)
  );

  // Fetch freezes in the accept cycle itself, before the sequencer leaves IDLE.
  assign stall_fetch = run || accept;
  assign uop_valid   = run && low_any;
  assign uop_is_load = run ? is_load : 1'b0;
  assign uop_reg     = run ? low_idx : 3'd0;
  assign uop_addr    = run ? addr : '0;
  assign rem_mask    = run ? mask : '0;

  // NOTE: sequential state is written only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mask    <= '0;
      addr    <= '0;
      is_load <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // An abandoned sequence never reports completion.
        state <= IDLE;
        mask  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              mask    <= list;
              addr    <= base_addr;
              is_load <= (opcode == OP_LM);
              if (list != '0) state <= RUN;
              else            done  <= 1'b1;
            end
          end
          RUN: begin
            if (!hold) begin
              mask <= mask_next;
              addr <= addr + ADDR_W'(1);
              if (mask_next == '0) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer: hand-computed micro-op streams for
// LM/SM lists, address wrap, hold, flush, reset and non-LM/SM instructions.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir_in;
  logic        ir_valid;
  logic [15:0] base_addr;
  logic        hold;
  logic        flush;
  logic        stall_fetch;
  logic        uop_valid;
  logic        uop_is_load;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;
  logic [7:0]  rem_mask;
  logic        done;

  int errors = 0;
  int checks = 0;

  lm_sm_sequencer #(.ADDR_W(16), .NREG(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .ir_in       (ir_in),
    .ir_valid    (ir_valid),
    .base_addr   (base_addr),
    .hold        (hold),
    .flush       (flush),
    .stall_fetch (stall_fetch),
    .uop_valid   (uop_valid),
    .uop_is_load (uop_is_load),
    .uop_reg     (uop_reg),
    .uop_addr    (uop_addr),
    .rem_mask    (rem_mask),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after a rising edge; outputs are sampled at the falling edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_uop(input string tag, input logic [2:0] r, input logic [15:0] a,
                         input logic ld, input logic [7:0] rem);
    @(negedge clk);
    check({tag, ".valid"}, uop_valid, 1);
    check({tag, ".reg"},   uop_reg, r);
    check({tag, ".addr"},  uop_addr, a);
    check({tag, ".load"},  uop_is_load, ld);
    check({tag, ".rem"},   rem_mask, rem);
    check({tag, ".stall"}, stall_fetch, 1);
    check({tag, ".done"},  done, 0);
    adv();
  endtask

  task automatic chk_idle(input string tag, input logic exp_done, input logic exp_stall);
    @(negedge clk);
    check({tag, ".valid"}, uop_valid, 0);
    check({tag, ".done"},  done, exp_done);
    check({tag, ".stall"}, stall_fetch, exp_stall);
    check({tag, ".rem"},   rem_mask, 0);
    adv();
  endtask

  // Accept cycle: fetch stalls at once, no micro-op yet.
  task automatic issue(input string tag, input logic [15:0] ir, input logic [15:0] base);
    ir_in     = ir;
    ir_valid  = 1'b1;
    base_addr = base;
    chk_idle({tag, ".accept"}, 0, 1);
    ir_valid  = 1'b0;
    ir_in     = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ir_in = '0; ir_valid = 1'b0; base_addr = '0; hold = 1'b0; flush = 1'b0;
    adv();
    @(negedge clk);
    check("rst.valid", uop_valid, 0);
    check("rst.stall", stall_fetch, 0);
    check("rst.done",  done, 0);
    check("rst.reg",   uop_reg, 0);
    check("rst.addr",  uop_addr, 0);
    check("rst.rem",   rem_mask, 0);
    adv();
    reset = 1'b0;
    chk_idle("post_rst", 0, 0);

    // LM 0x6C25, list 0b00100101 at base 0x0100.
    issue("lm25", 16'h6C25, 16'h0100);
    chk_uop("lm25.u0", 3'd0, 16'h0100, 1, 8'h25);
    chk_uop("lm25.u1", 3'd2, 16'h0101, 1, 8'h24);
    chk_uop("lm25.u2", 3'd5, 16'h0102, 1, 8'h20);
    chk_idle("lm25.done", 1, 0);
    chk_idle("lm25.after", 0, 0);

    // SM single register 7 at 0xFFFF.
    issue("sm80", 16'h7080, 16'hFFFF);
    chk_uop("sm80.u0", 3'd7, 16'hFFFF, 0, 8'h80);
    chk_idle("sm80.done", 1, 0);
    chk_idle("sm80.after", 0, 0);

    // SM list 0x03 at 0xFFFF: address wraps to 0x0000.
    issue("sm03", 16'h7003, 16'hFFFF);
    chk_uop("sm03.u0", 3'd0, 16'hFFFF, 0, 8'h03);
    chk_uop("sm03.u1", 3'd1, 16'h0000, 0, 8'h02);
    chk_idle("sm03.done", 1, 0);

    // LM list 0xFF, third micro-op held for two extra cycles; done at T+11.
    issue("lmff", 16'h60FF, 16'h0200);
    chk_uop("lmff.u0", 3'd0, 16'h0200, 1, 8'hFF);
    chk_uop("lmff.u1", 3'd1, 16'h0201, 1, 8'hFE);
    hold = 1'b1;
    chk_uop("lmff.u2h0", 3'd2, 16'h0202, 1, 8'hFC);
    chk_uop("lmff.u2h1", 3'd2, 16'h0202, 1, 8'hFC);
    hold = 1'b0;
    chk_uop("lmff.u2", 3'd2, 16'h0202, 1, 8'hFC);
    chk_uop("lmff.u3", 3'd3, 16'h0203, 1, 8'hF8);
    chk_uop("lmff.u4", 3'd4, 16'h0204, 1, 8'hF0);
    chk_uop("lmff.u5", 3'd5, 16'h0205, 1, 8'hE0);
    chk_uop("lmff.u6", 3'd6, 16'h0206, 1, 8'hC0);
    chk_uop("lmff.u7", 3'd7, 16'h0207, 1, 8'h80);
    chk_idle("lmff.done", 1, 0);

    // LM empty list: no micro-ops, done the next cycle.
    issue("lm00", 16'h6000, 16'h0400);
    chk_idle("lm00.done", 1, 0);
    chk_idle("lm00.after", 0, 0);

    // SM 0x0F, flush together with hold during the second micro-op.
    issue("sm0f", 16'h700F, 16'h0300);
    chk_uop("sm0f.u0", 3'd0, 16'h0300, 0, 8'h0F);
    flush = 1'b1;
    hold  = 1'b1;
    chk_uop("sm0f.u1", 3'd1, 16'h0301, 0, 8'h0E);
    flush = 1'b0;
    hold  = 1'b0;
    chk_idle("sm0f.flushed", 0, 0);
    chk_idle("sm0f.after", 0, 0);

    // Reset mid-sequence returns every output to zero.
    issue("lm07", 16'h6007, 16'h1234);
    chk_uop("lm07.u0", 3'd0, 16'h1234, 1, 8'h07);
    reset = 1'b1;
    chk_uop("lm07.u1", 3'd1, 16'h1235, 1, 8'h06);
    reset = 1'b0;
    @(negedge clk);
    check("lm07.rst.valid", uop_valid, 0);
    check("lm07.rst.stall", stall_fetch, 0);
    check("lm07.rst.done",  done, 0);
    check("lm07.rst.reg",   uop_reg, 0);
    check("lm07.rst.addr",  uop_addr, 0);
    check("lm07.rst.load",  uop_is_load, 0);
    check("lm07.rst.rem",   rem_mask, 0);
    adv();

    // ADD held valid in IDLE: ignored.
    ir_in = 16'h0A50; ir_valid = 1'b1; base_addr = 16'h5555;
    chk_idle("add.c0", 0, 0);
    chk_idle("add.c1", 0, 0);
    ir_valid = 1'b0;
    chk_idle("add.c2", 0, 0);

    // LM 0x61FF: IR[8] set but ignored, full eight transfers from 0x0000.
    issue("lm1ff", 16'h61FF, 16'h0000);
    for (int i = 0; i < 8; i++)
      chk_uop($sformatf("lm1ff.u%0d", i), 3'(i), 16'(i), 1, 8'hFF << i);
    chk_idle("lm1ff.done", 1, 0);
    chk_idle("lm1ff.after", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
